mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative RV32M multiply/divide unit in the Execute stage. It accepts one M-extension operation from the E-stage operands and computes it over multiple cycles. It signals completion with a one-cycle `OkE` pulse, which the hazard unit uses to hold F/D/E stalled until the result is ready. It is the producer side of the execute-unit "ok" handshake that the hazard logic consumes.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `CNTW`, default 6: iteration counter width; must hold the value `XLEN`.

Ports:
- `clk`: input, 1 bit. Single clock, rising-edge.
- `reset_n`: input, 1 bit. Reset is asynchronous and active-low.
- `StartE`: input, 1 bit. An M-op is present in E. Held high by the pipeline until `OkE` is seen.
- `FunctE`: input, 3 bits. funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE`: input, `XLEN` bits. rs1 operand, already forwarded.
- `SrcBE`: input, `XLEN` bits. rs2 operand, already forwarded.
- `FlushE`: input, 1 bit. Kills the in-flight op.
- `BusyE`: output, 1 bit. High whenever state is not IDLE.
- `OkE`: output, 1 bit. One-cycle pulse; `ResultE` is valid in that cycle.
- `ResultE`: output, `XLEN` bits. Result; holds its last value until the next `OkE`.

## Operation
States: IDLE, CALC, FAST, DONE.
- **IDLE**
  - `StartE` & !`FlushE`: latch operands, funct3 and sign flags, then go to CALC with counter = `XLEN`.
  - Special-case divide/remainder: go to FAST instead.
- **CALC**
  - One iteration per cycle; counter decrements.
  - At counter = 1, go to DONE.
- **FAST**: load the special result, then go to DONE.
- **DONE**
  - `OkE`=1 and `ResultE` updated, then go to IDLE unconditionally.
  - `StartE` in DONE is ignored; a new op is accepted from IDLE only.
- **Flush**: `FlushE` in any state → IDLE on the next edge. No `OkE`; `ResultE` unchanged.
- **Multiply**
  - Magnitudes: A is signed for MULH/MULHSU; B is signed for MULH only.
  - Unsigned shift-add into a 2·`XLEN` accumulator, one bit per iteration.
  - Negate the product if the operand signs differ.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- **Divide**
  - Restoring divide on magnitudes (signed for DIV/REM), one quotient bit per iteration.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- **Special cases** (FAST path):
  - Divisor = 0: quotient = all ones; remainder = dividend (DIV, DIVU, REM, REMU).
  - Signed overflow, dividend = 0x80000000 with divisor = 0xFFFFFFFF: DIV = 0x80000000, REM = 0.
- Operands are latched at accept; changes on `SrcAE`/`SrcBE` afterwards have no effect.

## Timing
- **Reset** (async, `reset_n`=0): state = IDLE, counter = 0, `BusyE` = 0, `OkE` = 0, `ResultE` = 0, accumulators = 0. Release is synchronous to the next edge.
- **Normal latency**: `StartE` sampled in IDLE at edge T → `OkE` high in cycle T+`XLEN`+1, i.e. cycle 33 for `XLEN`=32.
- **FAST latency**: `OkE` high in cycle T+2.
- **Stall rule**: the hazard unit stalls while `StartE` & !`OkE`. The pipeline advances on the `OkE` cycle.
- **Back-to-back ops**: a new op is presented the cycle after `OkE`, state is IDLE, and it is accepted. There are no bubbles beyond the DONE→IDLE cycle.
- **Flush precedence**:
  - `FlushE` and `StartE` in the same IDLE cycle: the op is not accepted.
  - `FlushE` in the DONE cycle: `OkE` is suppressed.
- `BusyE` rises the cycle after accept and falls the cycle after DONE.

## Structure
- **Package `mdu_pkg`**:
  - `mdu_state_t` enum (IDLE, CALC, FAST, DONE).
  - `mdu_op_t` enum of the eight funct3 codes.
  - Constants `MDU_DIV_BIT` (funct3[2]) and `MDU_MIN_INT` = 0x80000000.
- **Sub-module `mdu_datapath`**: holds the accumulators, shift-add/subtract step, sign fix-up and special-result mux. It is driven by load/step/fix controls from the FSM in `mdu_iter`.

## Test plan
- MUL 0x00000007 × 0x00000006 → `OkE` at cycle 33, `ResultE` = 0x0000002A, `BusyE` low the following cycle.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → `ResultE` = 0x00000000. MULHU of the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM of the same → 0xFFFFFFFF (−1). DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with `OkE` at cycle 2. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 2.
- Start DIV, assert `FlushE` at cycle 10 → `BusyE` = 0 at cycle 11, no `OkE`, `ResultE` unchanged. A new MUL 3×3 at cycle 12 → 9 at cycle 45.
- Drop `reset_n` mid-CALC at cycle 5 → `BusyE`, `OkE` and `ResultE` go to 0 immediately (async). After release, MULHU 0x80000000 × 2 → 0x00000001.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the
// iterative RV32M multiply/divide unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FAST,
      S_DONE
   } mdu_state_t;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_t;

   localparam int          MDU_DIV_BIT = 2;
   localparam logic [31:0] MDU_MIN_INT = 32'h8000_0000;

endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: accumulators, shift-add / restoring-
// subtract step, sign fix-up and special-result load.
module mdu_datapath
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load_i,
   input  logic            step_i,
   input  logic            fix_i,
   input  logic [2:0]      funct_i,
   input  logic [XLEN-1:0] srca_i,
   input  logic [XLEN-1:0] srcb_i,
   output logic            special_o,
   output logic [XLEN-1:0] res_o
);

   localparam logic [XLEN-1:0] MinInt = (XLEN == 32) ?
      XLEN'(MDU_MIN_INT) : {1'b1, {(XLEN-1){1'b0}}};

   mdu_op_t         op, op_q;
   logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic            div_zero, ovf;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN-1:0] hi_q, lo_q, m_q;
   logic            negq_q, negr_q;
   logic [XLEN-1:0] res_q;
   logic [XLEN:0]   sum, rs, diff;
   logic [XLEN-1:0] nhi, nlo;
   logic [2*XLEN-1:0] prod, sprod;
   logic [XLEN-1:0] quo, rem, fixres;

   // Operand decode: signedness, magnitudes, special cases
   always_comb begin
      op     = mdu_op_t'(funct_i);
      is_div = funct_i[MDU_DIV_BIT];
      a_sgn  = is_div ? (op == OP_DIV || op == OP_REM)
                      : (op == OP_MULH || op == OP_MULHSU);
      b_sgn  = is_div ? a_sgn : (op == OP_MULH);
      a_neg  = a_sgn & srca_i[XLEN-1];
      b_neg  = b_sgn & srcb_i[XLEN-1];
      a_mag  = a_neg ? -srca_i : srca_i;
      b_mag  = b_neg ? -srcb_i : srcb_i;
      div_zero = is_div && (srcb_i == '0);
      ovf      = is_div && a_sgn && (srca_i == MinInt)
                 && (srcb_i == '1);
      special_o = div_zero | ovf;
   end

   // One iteration: shift-add multiply or restoring divide
   always_comb begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      rs   = {hi_q, lo_q[XLEN-1]};
      diff = rs - {1'b0, m_q};
      nhi  = hi_q;
      nlo  = lo_q;
      if (step_i) begin
         if (op_q[MDU_DIV_BIT]) begin
            if (!diff[XLEN]) begin
               nhi = diff[XLEN-1:0];
               nlo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               nhi = rs[XLEN-1:0];
               nlo = {lo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            nhi = sum[XLEN:1];
            nlo = {sum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   // Sign fix-up and result select
   always_comb begin
      prod  = {nhi, nlo};
      sprod = negq_q ? -prod : prod;
      quo   = negq_q ? -nlo : nlo;
      rem   = negr_q ? -nhi : nhi;
      case (op_q)
         OP_MUL:                        fixres = sprod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fixres = sprod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               fixres = quo;
         default:                       fixres = rem;
      endcase
   end

   // Accumulator and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q   <= OP_MUL;
         hi_q   <= '0;
         lo_q   <= '0;
         m_q    <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         res_q  <= '0;
      end else begin
         if (load_i) begin
            op_q   <= op;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            m_q    <= is_div ? b_mag : a_mag;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            if (div_zero) begin
               hi_q   <= srca_i;
               lo_q   <= '1;
               negq_q <= 1'b0;
               negr_q <= 1'b0;
            end else if (ovf) begin
               lo_q   <= MinInt;
               negq_q <= 1'b0;
               negr_q <= 1'b0;
            end
         end else if (step_i) begin
            hi_q <= nhi;
            lo_q <= nlo;
         end
         if (fix_i)
            res_q <= fixres;
      end
   end

   assign res_o = res_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with
// a one-cycle OkE completion pulse for the hazard unit.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int CNTW = 6
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            StartE,
   input  logic [2:0]      FunctE,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            FlushE,
   output logic            BusyE,
   output logic            OkE,
   output logic [XLEN-1:0] ResultE
);

   mdu_state_t      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] result_q;
   logic [XLEN-1:0] res;
   logic            load, step, fix, ok, special;

   mdu_datapath #(.XLEN(XLEN)) u_dp (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (load),
      .step_i    (step),
      .fix_i     (fix),
      .funct_i   (FunctE),
      .srca_i    (SrcAE),
      .srcb_i    (SrcBE),
      .special_o (special),
      .res_o     (res)
   );

   // Next-state and datapath controls; flush wins
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      ok      = 1'b0;
      if (FlushE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (StartE) begin
                  load = 1'b1;
                  if (special) begin
                     state_d = S_FAST;
                     cnt_d   = '0;
                  end else begin
                     state_d = S_CALC;
                     cnt_d   = CNTW'(XLEN);
                  end
               end
            end
            S_CALC: begin
               step  = 1'b1;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNTW'(1)) begin
                  fix     = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_FAST: begin
               fix     = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               ok      = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, counter and held result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (ok)
            result_q <= res;
      end
   end

   assign BusyE   = (state_q != S_IDLE);
   assign OkE     = ok;
   assign ResultE = ok ? res : result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of
// mdu_iter against an arithmetic reference model.
module tb_mdu_iter;

   localparam int XLEN = 32;
   localparam int LAT_CALC = XLEN;
   localparam int LAT_FAST = 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        StartE = 1'b0;
   logic [2:0]  FunctE = 3'b000;
   logic [31:0] SrcAE = '0;
   logic [31:0] SrcBE = '0;
   logic        FlushE = 1'b0;
   logic        BusyE, OkE;
   logic [31:0] ResultE;

   int n_tests = 0;
   int n_fail  = 0;

   mdu_iter #(.XLEN(XLEN), .CNTW(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .StartE  (StartE),
      .FunctE  (FunctE),
      .SrcAE   (SrcAE),
      .SrcBE   (SrcBE),
      .FlushE  (FlushE),
      .BusyE   (BusyE),
      .OkE     (OkE),
      .ResultE (ResultE)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mdu(
      input logic [2:0] f,
      input logic [31:0] a,
      input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      r = '0;
      case (f)
         3'b000: begin p = 64'(ua * ub); r = p[31:0]; end
         3'b001: begin p = 64'(sa * sb); r = p[63:32]; end
         3'b010: begin p = 64'(sa * ub); r = p[63:32]; end
         3'b011: begin p = 64'(ua * ub); r = p[63:32]; end
         3'b100:
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = 32'h8000_0000;
            else r = 32'(sa / sb);
         3'b101:
            if (b == 0) r = 32'hFFFF_FFFF;
            else r = 32'(ua / ub);
         3'b110:
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = 32'h0;
            else r = 32'(sa % sb);
         default:
            if (b == 0) r = a;
            else r = 32'(ua % ub);
      endcase
      return r;
   endfunction

   function automatic int ref_lat(
      input logic [2:0] f,
      input logic [31:0] a,
      input logic [31:0] b);
      if (f[2] && b == 0) return LAT_FAST;
      if ((f == 3'b100 || f == 3'b110) &&
          a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return LAT_FAST;
      return LAT_CALC;
   endfunction

   // Present an op, scramble operands after accept,
   // wait for OkE; lat = edges from accept to OkE.
   task automatic run_op(
      input  logic [2:0]  f,
      input  logic [31:0] a,
      input  logic [31:0] b,
      output logic [31:0] res,
      output int          lat);
      @(negedge clk);
      StartE = 1'b1;
      FunctE = f;
      SrcAE  = a;
      SrcBE  = b;
      @(posedge clk);
      #1;
      SrcAE = $urandom;
      SrcBE = $urandom;
      res = 'x;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (OkE) begin
            res = ResultE;
            lat = i;
            break;
         end
      end
      @(negedge clk);
      StartE = 1'b0;
   endtask

   task automatic check_op(
      input string name,
      input logic [2:0]  f,
      input logic [31:0] a,
      input logic [31:0] b);
      logic [31:0] res, exp;
      int lat, elat;
      exp  = ref_mdu(f, a, b);
      elat = ref_lat(f, a, b);
      run_op(f, a, b, res, lat);
      n_tests++;
      if (res !== exp) begin
         n_fail++;
         $display("FAIL %s result: got %h expected %h", name, res, exp);
      end
      n_tests++;
      if (lat !== elat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
      end
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (BusyE !== 1'b0 || OkE !== 1'b0 || ResultE !== 32'h0) begin
         n_fail++;
         $display("FAIL reset: busy=%b ok=%b res=%h expected 0 0 0",
                  BusyE, OkE, ResultE);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      check_op("mul_7x6", 3'b000, 32'h7, 32'h6);
      @(posedge clk);
      #1;
      n_tests++;
      if (BusyE !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_done: got %b expected 0", BusyE);
      end
      check_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_op("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h2);
   endtask

   task automatic test_div();
      check_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'h2);
      check_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'h2);
      check_op("divu_100_7", 3'b101, 32'd100, 32'd7);
      check_op("remu_100_7", 3'b111, 32'd100, 32'd7);
   endtask

   task automatic test_special();
      check_op("divu_by0", 3'b101, 32'd5, 32'd0);
      check_op("rem_by0", 3'b110, 32'd5, 32'd0);
      check_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      check_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_flush();
      logic [31:0] prev;
      bit seen_ok;
      prev = ResultE;
      seen_ok = 0;
      @(negedge clk);
      StartE = 1'b1;
      FunctE = 3'b100;
      SrcAE  = 32'd1000;
      SrcBE  = 32'd3;
      @(posedge clk);
      repeat (8) begin
         @(posedge clk);
         #1;
         if (OkE) seen_ok = 1;
      end
      @(negedge clk);
      FlushE = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (BusyE !== 1'b0 || seen_ok) begin
         n_fail++;
         $display("FAIL flush_calc: busy=%b ok_seen=%0d expected 0 0",
                  BusyE, seen_ok);
      end
      @(negedge clk);
      FlushE = 1'b0;
      StartE = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (OkE) seen_ok = 1;
      end
      n_tests++;
      if (seen_ok || ResultE !== prev) begin
         n_fail++;
         $display("FAIL flush_noresult: ok_seen=%0d res=%h expected 0 %h",
                  seen_ok, ResultE, prev);
      end
      check_op("mul_3x3_after_flush", 3'b000, 32'd3, 32'd3);
      // start and flush together in IDLE: not accepted
      @(negedge clk);
      StartE = 1'b1;
      FlushE = 1'b1;
      FunctE = 3'b000;
      SrcAE  = 32'd5;
      SrcBE  = 32'd5;
      @(posedge clk);
      #1;
      n_tests++;
      if (BusyE !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_start_idle: busy=%b expected 0", BusyE);
      end
      // flush in DONE: FAST op, flush on its DONE cycle
      prev = ResultE;
      @(negedge clk);
      FlushE = 1'b0;
      FunctE = 3'b101;
      SrcAE  = 32'd77;
      SrcBE  = 32'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      FlushE = 1'b1;
      #1;
      n_tests++;
      if (BusyE !== 1'b1 || OkE !== 1'b0 || ResultE !== prev) begin
         n_fail++;
         $display("FAIL flush_done: busy=%b ok=%b res=%h expected 1 0 %h",
                  BusyE, OkE, ResultE, prev);
      end
      @(negedge clk);
      StartE = 1'b0;
      @(posedge clk);
      #1;
      FlushE = 1'b0;
      n_tests++;
      if (BusyE !== 1'b0 || ResultE !== prev) begin
         n_fail++;
         $display("FAIL flush_done_after: busy=%b res=%h expected 0 %h",
                  BusyE, ResultE, prev);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      StartE = 1'b1;
      FunctE = 3'b000;
      SrcAE  = 32'd11;
      SrcBE  = 32'd13;
      repeat (5) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (BusyE !== 1'b0 || OkE !== 1'b0 || ResultE !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b ok=%b res=%h expected 0 0 0",
                  BusyE, OkE, ResultE);
      end
      StartE = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_op("mulhu_after_reset", 3'b011, 32'h8000_0000, 32'h2);
   endtask

   task automatic test_back_to_back();
      logic [31:0] r1, r2, e1, e2;
      int l1, l2;
      e1 = ref_mdu(3'b000, 32'd12, 32'd12);
      e2 = ref_mdu(3'b111, 32'd12, 32'd5);
      run_op(3'b000, 32'd12, 32'd12, r1, l1);
      run_op(3'b111, 32'd12, 32'd5, r2, l2);
      n_tests++;
      if (r1 !== e1 || r2 !== e2 || l1 != LAT_CALC || l2 != LAT_CALC) begin
         n_fail++;
         $display("FAIL back_to_back: got %h/%0d %h/%0d expected %h/%0d %h/%0d",
                  r1, l1, r2, l2, e1, LAT_CALC, e2, LAT_CALC);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [2:0] f;
      for (int i = 0; i < 150; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         check_op($sformatf("rand%0d_f%0d", i, f), f, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
